// File: rtl/counter_pkg.sv
// Shared definitions for the lab counters: the countdown FSM state encoding
// and the default width / prescale constants.
package counter_pkg;

    // Countdown timer states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH    = 16;
    localparam int DEFAULT_PRESCALE = 100_000;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..PRESCALE-1 while en is high and emits a one-cycle
// tick on the cycle the count sits at PRESCALE-1. clr is synchronous and
// wins over en. When en is low the count is held, so a paused period can
// be resumed where it left off.
module tick_gen #(
    parameter int PRESCALE = 100_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] pre_q;

    // Prescale counter: clear, wrap at LAST, otherwise step while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else if (clr) begin
            pre_q <= '0;
        end else if (en) begin
            if (pre_q == LAST) begin
                pre_q <= '0;
            end else begin
                pre_q <= pre_q + CW'(1);
            end
        end
    end

    assign tick = en && (pre_q == LAST);

endmodule

// File: rtl/countdown_timer16.sv
// Loadable down-counter driven by a prescaled tick, with start/stop/load
// commands (priority load > stop > start), a one-cycle done pulse on the
// terminal tick and an expired level.
// Optional feature: COUNTDOWN_AUTO_RELOAD_EN -- when defined, the terminal
// tick reloads the count from the reload register and the timer keeps
// running instead of entering EXPIRED.
module countdown_timer16
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             done,
    output logic             expired
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             running_q, expired_q;
    logic             tick;
    logic             pre_en, pre_clr;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q;

    // Reload register: captures the value on every load.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            reload_q <= '0;
        end else if (load) begin
            reload_q <= load_value;
        end
    end
`endif

    // Prescaler only advances in RUN; load restarts the tick period.
    assign pre_en  = (state_q == ST_RUN);
    assign pre_clr = load;

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk   (CLK100MHZ),
        .rst_n (CPU_RESETN),
        .en    (pre_en),
        .clr   (pre_clr),
        .tick  (tick)
    );

    // State, count and flag registers.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            done_q    <= done_d;
            running_q <= (state_d == ST_RUN);
            expired_q <= (state_d == ST_EXPIRED);
        end
    end

    // Next-state and next-count: load beats stop beats start; a stop or a
    // load on a tick cycle suppresses the decrement.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (load) begin
            count_d = load_value;
            state_d = ST_IDLE;
        end else if (stop) begin
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSE;
            end
        end else begin
            case (state_q)
                ST_IDLE, ST_PAUSE: begin
                    if (start && (count_q != '0)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        if (count_q == WIDTH'(1)) begin
                            done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            count_d = reload_q;
`else
                            count_d = '0;
                            state_d = ST_EXPIRED;
`endif
                        end else begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end
                end
                ST_EXPIRED: begin
                    count_d = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign count   = count_q;
    assign done    = done_q;
    assign running = running_q;
    assign expired = expired_q;

endmodule

// File: tb/tb_countdown_timer16.sv
// Directed bench for countdown_timer16 with PRESCALE = 4. Inputs change
// 1 ns after a rising edge and outputs are checked at that same point.
module tb_countdown_timer16;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         load;
    logic [W-1:0] load_value;
    logic         start;
    logic         stop;
    logic [W-1:0] count;
    logic         running;
    logic         done;
    logic         expired;

    int n_total;
    int n_bad;

    countdown_timer16 #(
        .WIDTH(W),
        .PRESCALE(4)
    ) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .stop       (stop),
        .count      (count),
        .running    (running),
        .done       (done),
        .expired    (expired)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock; return 1 ns after the rising edge.
    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load = 1'b1;
        load_value = v;
        cyc();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_bad = 0;
        load = 1'b0;
        load_value = '0;
        start = 1'b0;
        stop = 1'b0;
        rst_n = 1'b0;
        #3;
        check("rst_count", count, 0);
        check("rst_running", running, 0);
        check("rst_done", done, 0);
        check("rst_expired", expired, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc();

`ifndef COUNTDOWN_AUTO_RELOAD_EN
        // Basic countdown 3 -> 0
        do_load(16'd3);
        check("ld3_count", count, 3);
        check("ld3_running", running, 0);
        do_start();
        check("st_running", running, 1);
        cyc(3);
        check("pre_dec_3", count, 3);
        cyc();
        check("dec_2", count, 2);
        cyc(4);
        check("dec_1", count, 1);
        cyc(3);
        check("pre_term_count", count, 1);
        check("pre_term_done", done, 0);
        cyc();
        check("term_count", count, 0);
        check("term_done", done, 1);
        check("term_expired", expired, 1);
        check("term_running", running, 0);
        cyc();
        check("done_single", done, 0);
        check("exp_hold", expired, 1);

        // EXPIRED ignores start
        do_start();
        cyc(5);
        check("exp_start_running", running, 0);
        check("exp_start_count", count, 0);
        check("exp_start_done", done, 0);
        // load leaves EXPIRED
        do_load(16'd2);
        check("exp_ld_expired", expired, 0);
        check("exp_ld_count", count, 2);
        check("exp_ld_running", running, 0);
`else
        // Auto-reload: 2,1,2,1 with done on each reload
        do_load(16'd2);
        do_start();
        cyc(4);
        check("ar_dec_1", count, 1);
        check("ar_done0", done, 0);
        cyc(4);
        check("ar_reload", count, 2);
        check("ar_done", done, 1);
        check("ar_expired", expired, 0);
        check("ar_running", running, 1);
        cyc();
        check("ar_done_single", done, 0);
        cyc(3);
        check("ar_dec_1b", count, 1);
        cyc(4);
        check("ar_reload_b", count, 2);
        check("ar_done_b", done, 1);
        check("ar_expired_b", expired, 0);
`endif

        // Zero guard
        do_load(16'd0);
        do_start();
        check("zero_running", running, 0);
        cyc(6);
        check("zero_done", done, 0);
        check("zero_count", count, 0);
        check("zero_expired", expired, 0);

        // Pause and resume: stop 2 cycles into the period
        do_load(16'd5);
        do_start();
        cyc();
        do_stop();
        check("pause_running", running, 0);
        check("pause_count", count, 5);
        cyc(10);
        check("pause_hold", count, 5);
        do_start();
        check("resume_running", running, 1);
        check("resume_count0", count, 5);
        cyc();
        check("resume_count1", count, 5);
        cyc();
        check("resume_dec", count, 4);

        // load + start together while running: load wins
        load = 1'b1;
        load_value = 16'd9;
        start = 1'b1;
        cyc();
        load = 1'b0;
        start = 1'b0;
        check("prio_count", count, 9);
        check("prio_running", running, 0);
        cyc(5);
        check("prio_idle_hold", count, 9);

        // stop on the tick cycle: no decrement
        do_start();
        cyc(3);
        do_stop();
        check("stop_tick_count", count, 9);
        check("stop_tick_running", running, 0);
        cyc(4);
        check("stop_tick_hold", count, 9);

        // load on the terminal tick cycle: no done, no expiry
        do_load(16'd1);
        do_start();
        cyc(3);
        do_load(16'd7);
        check("ld_tick_count", count, 7);
        check("ld_tick_done", done, 0);
        check("ld_tick_expired", expired, 0);
        check("ld_tick_running", running, 0);

        // asynchronous reset mid-count
        do_start();
        cyc(5);
        check("pre_rst_count", count, 6);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_running", running, 0);
        check("arst_done", done, 0);
        check("arst_expired", expired, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/countdown_timer16.md
# countdown_timer16

Loadable 16-bit down-counter that counts the opposite way to the lab's free-running 16-bit up-counter, using the same 100 MHz board clock. It runs from an internal prescaled tick and supports start, pause and load commands. When the count reaches zero it raises a one-cycle terminal pulse and an expired flag. It sits beside the up-counter in the lab top level and drives LEDs or the display path with a 16-bit countdown value.

## Interface
- `WIDTH`, 16: counter width in bits.
- `PRESCALE`, 100_000: clock cycles per count tick; must be ≥ 2. Default gives 1 kHz at 100 MHz.
- `CLK100MHZ` in 1: system clock, 100 MHz.
- `CPU_RESETN` in 1: reset, asynchronous, active-low.
- `load` in 1: pulse; copies `load_value` into the count and the reload register.
- `load_value` in WIDTH: value captured on `load`.
- `start` in 1: pulse; begins or resumes counting.
- `stop` in 1: pulse; pauses counting.
- `count` out WIDTH: current count value (registered).
- `running` out 1: high while in RUN.
- `done` out 1: one-cycle pulse on terminal count.
- `expired` out 1: level; high in EXPIRED state.

## Operation
- States:
  - IDLE: loaded, not started.
  - RUN: counting.
  - PAUSE: stopped mid-count.
  - EXPIRED: count reached 0.
- Command priority when inputs coincide: `load` > `stop` > `start`.
- `load` from any state:
  - `count` ← `load_value`; reload register ← `load_value`.
  - Prescaler cleared to 0; state → IDLE.
- `start`:
  - From IDLE or PAUSE with `count` ≠ 0: state → RUN.
  - With `count` = 0: ignored. No `done` pulse; state unchanged.
  - In RUN: no effect.
- `stop` in RUN: state → PAUSE. The prescaler value is held, not cleared, so a resume continues the partial tick period.
- Prescaler:
  - Increments only in RUN, wrapping PRESCALE−1 → 0.
  - A tick fires on the cycle the prescaler equals PRESCALE−1.
- On a tick, `count` decrements by 1.
- Terminal tick (`count` = 1 when the tick fires):
  - `count` → 0 and `done` = 1 in the same registered cycle.
  - State → EXPIRED.
- EXPIRED: holds `count` = 0. Only `load` leaves this state.
- No wrap-around: `count` never decrements below 0.

## Timing
- Reset values: `count` = 0, `running` = 0, `done` = 0, `expired` = 0, state = IDLE, prescaler = 0, reload register = 0.
- Outputs are registered. A command sampled at edge k is visible after edge k.
- First decrement after `start`: PRESCALE cycles after the edge that samples `start` (prescaler at 0). A resume after pause takes the remaining cycles only.
- `done` is high for exactly one clock.
- `expired` rises on the same edge as `done`.
- `running` = 1 exactly while in RUN.
- `load` and a tick in the same cycle: `load` wins; no decrement, no `done`.
- `stop` and a tick in the same cycle: `stop` wins; no decrement.
- Reset asserted mid-count: all outputs go to reset values immediately, without waiting for a clock.

## Configuration
- Macro: `COUNTDOWN_AUTO_RELOAD_EN`.
- Defined:
  - The terminal tick pulses `done` and loads `count` ← reload register; state stays RUN.
  - `expired` is never asserted; `count` never shows 0 while running.
  - Period is reload × PRESCALE cycles.
  - A reload value of 0 still blocks `start`.
- Undefined: the terminal tick moves the block to EXPIRED, as described in Operation.

## Structure
- Shared package `counter_pkg`:
  - State encoding constants for IDLE, RUN, PAUSE, EXPIRED (2 bits).
  - Default `PRESCALE` and `WIDTH` constants.
- Sub-module `tick_gen`:
  - Parameterised prescaler with an `en` input, a synchronous `clr` input, and a one-cycle `tick` output.
  - Width is $clog2(PRESCALE).
- FSM and count register live in the top module.

## Test plan
All scenarios run with PRESCALE = 4.
- Reset check: drive `CPU_RESETN` low → `count` = 0, `running` = 0, `expired` = 0, `done` = 0, asynchronously.
- Basic countdown: `load` 3, then `start` → `count` steps 3 → 2 → 1 → 0 with 4 cycles between steps. `done` is a single-cycle pulse together with `count` = 0. `expired` = 1 and `running` = 0 afterwards.
- Pause and resume: `load` 5, `start`, `stop` 2 cycles into a tick period, hold 10 cycles (`count` stays 5), then `start` → next decrement to 4 after exactly 2 more cycles.
- Priority: assert `load` (value 9) and `start` in the same cycle while in RUN → `count` = 9, state IDLE, no decrement. Assert `stop` on a tick cycle → no decrement.
- Zero guard: `load` 0, then `start` → stays in IDLE, no `done`. In EXPIRED, `start` is ignored; `load` 2 returns to IDLE.
- Auto-reload (macro defined): `load` 2, `start` → `count` sequence 2, 1, 2, 1, … with `done` pulsed each time the count reloads from 1 to 2. `expired` stays 0.
